// File: rtl/c_tile_serializer.sv
// rtl/c_tile_serializer.sv - framed LSB-first serializer for one ROWS x COLS accumulator tile
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   c_valid, c_ready    tile handshake; c_ready is high only while idle
//   c_tile              flattened tile, element (r,c) at [(r*COLS+c)*ACCW +: ACCW]
//   ser_en              bit-slot strobe; the serial state only moves when high
//   C_out_serial_data   registered serial data, row-major, LSB first
//   C_out_frame_sync    registered frame start marker, one slot before bit 0
//   busy                a frame is in progress
//   frame_done          one-cycle pulse after the last bit slot
module c_tile_serializer #(
    parameter int ACCW = 32,
    parameter int ROWS = 4,
    parameter int COLS = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       c_valid,
    output logic                       c_ready,
    input  logic [ROWS*COLS*ACCW-1:0]  c_tile,
    input  logic                       ser_en,
    output logic                       C_out_serial_data,
    output logic                       C_out_frame_sync,
    output logic                       busy,
    output logic                       frame_done
);

    localparam int NEL = ROWS * COLS;
    localparam int NB  = NEL * ACCW;
    localparam int EW  = (NEL > 1)  ? $clog2(NEL)  : 1;
    localparam int BW  = (ACCW > 1) ? $clog2(ACCW) : 1;
    localparam int IW  = (NB > 1)   ? $clog2(NB)   : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SYNC  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [EW-1:0]   elem_cnt;
    logic [BW-1:0]   bit_cnt;
    logic [NB-1:0]   snap;
    logic            data_nxt, sync_nxt, done_nxt;
    logic            last_bit, elem_wrap;
    logic [IW-1:0]   bit_idx;

    assign c_ready   = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign elem_wrap = (bit_cnt == BW'(ACCW - 1));
    assign last_bit  = elem_wrap && (elem_cnt == EW'(NEL - 1));
    // Row-major element order matches the flattening of c_tile, so the
    // stream position is simply element*ACCW + bit.
    assign bit_idx   = IW'(elem_cnt) * IW'(ACCW) + IW'(bit_cnt);

    // Snapshot is taken at the handshake so upstream is free afterwards.
    always_ff @(posedge clk) begin
        if (c_valid && c_ready) begin
            snap <= c_tile;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; acceptance in IDLE ignores ser_en.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (c_valid)             state_nxt = S_SYNC;
            S_SYNC:  if (ser_en)              state_nxt = S_SHIFT;
            S_SHIFT: if (ser_en && last_bit)  state_nxt = S_DONE;
            S_DONE:  if (ser_en)              state_nxt = S_IDLE;
            default:                          state_nxt = S_IDLE;
        endcase
    end

    // Output logic: next values for the registered serial outputs.
    // Without ser_en the data/sync registers hold; frame_done always self-clears.
    always_comb begin
        data_nxt = C_out_serial_data;
        sync_nxt = C_out_frame_sync;
        done_nxt = 1'b0;
        if (ser_en) begin
            case (state)
                S_SYNC: begin
                    data_nxt = 1'b0;
                    sync_nxt = 1'b1;
                end
                S_SHIFT: begin
                    data_nxt = snap[bit_idx];
                    sync_nxt = 1'b0;
                end
                S_DONE: begin
                    data_nxt = 1'b0;
                    sync_nxt = 1'b0;
                    done_nxt = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            C_out_serial_data <= 1'b0;
            C_out_frame_sync  <= 1'b0;
            frame_done        <= 1'b0;
        end else begin
            C_out_serial_data <= data_nxt;
            C_out_frame_sync  <= sync_nxt;
            frame_done        <= done_nxt;
        end
    end

    // Element/bit counters: cleared on the sync slot, stepped per shift slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            elem_cnt <= '0;
            bit_cnt  <= '0;
        end else if (ser_en) begin
            if (state == S_SYNC) begin
                elem_cnt <= '0;
                bit_cnt  <= '0;
            end else if (state == S_SHIFT) begin
                if (elem_wrap) begin
                    bit_cnt  <= '0;
                    elem_cnt <= elem_cnt + EW'(1);
                end else begin
                    bit_cnt  <= bit_cnt + BW'(1);
                end
            end
        end
    end

endmodule
